// File: rtl/graph_isa_pkg.sv
// graph_isa_pkg
// Shared graph-unit constants: SRAM0 arbiter requester IDs (the bit each
// engine drives on the arbiter req/grant vectors) and the default number
// of requesting engines.
package graph_isa_pkg;

  localparam int ARB_ID_CONCAT       = 0;
  localparam int ARB_ID_SPLIT        = 1;
  localparam int ARB_ID_COPY         = 2;
  localparam int ARB_ID_GATHER       = 3;
  localparam int ARB_NUM_REQ_DEFAULT = 4;

endpackage

// File: rtl/rr_pick.sv
// rr_pick
// Combinational round-robin picker: returns the index of the first set
// request bit at or after ptr, wrapping around N.
// Ports:
//   req  in  N   request vector
//   ptr  in  IW  search start position (always < N)
//   any  out 1   at least one request is set
//   idx  out IW  picked index (don't-care when any is 0)
module rr_pick #(
  parameter int N  = 4,
  parameter int IW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic          any,
  output logic [IW-1:0] idx
);

  logic [IW-1:0] cand_s;

  // Scan offsets from far to near so the closest set bit to ptr wins last.
  always_comb begin
    any    = |req;
    idx    = {IW{1'b0}};
    cand_s = {IW{1'b0}};
    for (int k = N - 1; k >= 0; k--) begin
      cand_s = IW'((int'(ptr) + k) % N);
      idx    = req[cand_s] ? cand_s : idx;
    end
  end

endmodule

// File: rtl/sram0_port_arbiter.sv
// sram0_port_arbiter
// Shares the single SRAM0 read/write port pair between NUM_REQ graph
// engines. Ownership is granted for a whole engine command (engines cannot
// stall), released only by the owner dropping req, and followed by one
// drain cycle. Read data returns only to the engine that issued the read.
// A watchdog flags ownerships lasting 2**WDOG_W-1 cycles without revoking.
// Ports:
//   clk, rst_n                         clock, async active-low reset
//   req / grant                        per-engine ownership request / one-hot grant
//   eng_rd_en/addr, eng_wr_en/addr/data  packed per-engine SRAM requests
//   eng_rd_data                        packed per-engine read return
//   sram_rd_*/sram_wr_*                SRAM0 macro port pair (read latency 1)
//   owner_id                           current or last owner index
//   wdog_err / wdog_clr                sticky timeout flag / its clear
module sram0_port_arbiter
  import graph_isa_pkg::*;
#(
  parameter int NUM_REQ  = ARB_NUM_REQ_DEFAULT,
  parameter int SRAM0_AW = 16,
  parameter int WDOG_W   = 20
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [NUM_REQ-1:0]            req,
  output logic [NUM_REQ-1:0]            grant,
  input  logic [NUM_REQ-1:0]            eng_rd_en,
  input  logic [NUM_REQ*SRAM0_AW-1:0]   eng_rd_addr,
  input  logic [NUM_REQ-1:0]            eng_wr_en,
  input  logic [NUM_REQ*SRAM0_AW-1:0]   eng_wr_addr,
  input  logic [NUM_REQ*8-1:0]          eng_wr_data,
  output logic [NUM_REQ*8-1:0]          eng_rd_data,
  output logic                          sram_rd_en,
  output logic [SRAM0_AW-1:0]           sram_rd_addr,
  input  logic [7:0]                    sram_rd_data,
  output logic                          sram_wr_en,
  output logic [SRAM0_AW-1:0]           sram_wr_addr,
  output logic [7:0]                    sram_wr_data,
  output logic [$clog2(NUM_REQ)-1:0]    owner_id,
  output logic                          wdog_err,
  input  logic                          wdog_clr
);

  localparam int ID_W = $clog2(NUM_REQ);
  localparam logic [ID_W-1:0]    ID_ONE   = ID_W'(1);
  localparam logic [ID_W-1:0]    ID_LAST  = ID_W'(NUM_REQ - 1);
  localparam logic [NUM_REQ-1:0] GNT_ONE  = NUM_REQ'(1);
  localparam logic [WDOG_W-1:0]  WDOG_MAX = {WDOG_W{1'b1}};
  localparam logic [WDOG_W-1:0]  WDOG_PRE = WDOG_MAX - WDOG_W'(1);

  typedef enum logic [1:0] {
    ARB_IDLE  = 2'd0,
    ARB_OWN   = 2'd1,
    ARB_DRAIN = 2'd2
  } arb_state_t;

  arb_state_t          state_r;
  logic [NUM_REQ-1:0]  grant_r;
  logic [ID_W-1:0]     owner_id_r;
  logic [ID_W-1:0]     rr_ptr_r;
  logic [ID_W-1:0]     rd_owner_r;
  logic                rd_vld_r;
  logic [WDOG_W-1:0]   wdog_cnt_r;
  logic                wdog_err_r;

  logic                pick_any_s;
  logic [ID_W-1:0]     pick_idx_s;
  logic                owner_req_s;
  logic                own_act_s;
  logic                wdog_set_s;

  rr_pick #(.N(NUM_REQ), .IW(ID_W)) u_rr_pick (
    .req (req),
    .ptr (rr_ptr_r),
    .any (pick_any_s),
    .idx (pick_idx_s)
  );

  assign owner_req_s = req[owner_id_r];
  assign own_act_s   = (state_r == ARB_OWN) && grant_r[owner_id_r];
  // The set event is the increment that lands the counter on all-ones.
  assign wdog_set_s  = (state_r == ARB_OWN) && owner_req_s && (wdog_cnt_r == WDOG_PRE);

  // Ownership FSM: grant, owner, round-robin pointer and watchdog counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r    <= ARB_IDLE;
      grant_r    <= {NUM_REQ{1'b0}};
      owner_id_r <= {ID_W{1'b0}};
      rr_ptr_r   <= {ID_W{1'b0}};
      wdog_cnt_r <= {WDOG_W{1'b0}};
    end else begin
      case (state_r)
        ARB_IDLE: begin
          if (pick_any_s) begin
            grant_r    <= GNT_ONE << pick_idx_s;
            owner_id_r <= pick_idx_s;
            rr_ptr_r   <= (pick_idx_s == ID_LAST) ? {ID_W{1'b0}} : pick_idx_s + ID_ONE;
            wdog_cnt_r <= {WDOG_W{1'b0}};
            state_r    <= ARB_OWN;
          end
        end
        ARB_OWN: begin
          if (!owner_req_s) begin
            grant_r <= {NUM_REQ{1'b0}};
            state_r <= ARB_DRAIN;
          end else if (wdog_cnt_r != WDOG_MAX) begin
            wdog_cnt_r <= wdog_cnt_r + WDOG_W'(1);
          end
        end
        ARB_DRAIN: begin
          state_r <= ARB_IDLE;
        end
        default: begin
          grant_r <= {NUM_REQ{1'b0}};
          state_r <= ARB_IDLE;
        end
      endcase
    end
  end

  // Read-return tag and sticky watchdog flag (set beats clear).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_vld_r   <= 1'b0;
      rd_owner_r <= {ID_W{1'b0}};
      wdog_err_r <= 1'b0;
    end else begin
      rd_vld_r   <= sram_rd_en;
      rd_owner_r <= owner_id_r;
      if (wdog_set_s) begin
        wdog_err_r <= 1'b1;
      end else if (wdog_clr) begin
        wdog_err_r <= 1'b0;
      end
    end
  end

  // Owner mux onto the SRAM port pair; everything is quiet outside ownership.
  always_comb begin
    sram_rd_en   = 1'b0;
    sram_rd_addr = {SRAM0_AW{1'b0}};
    sram_wr_en   = 1'b0;
    sram_wr_addr = {SRAM0_AW{1'b0}};
    sram_wr_data = 8'h00;
    if (own_act_s) begin
      sram_rd_en   = eng_rd_en[owner_id_r];
      sram_rd_addr = eng_rd_addr[int'(owner_id_r) * SRAM0_AW +: SRAM0_AW];
      sram_wr_en   = eng_wr_en[owner_id_r];
      sram_wr_addr = eng_wr_addr[int'(owner_id_r) * SRAM0_AW +: SRAM0_AW];
      sram_wr_data = eng_wr_data[int'(owner_id_r) * 8 +: 8];
    end else begin
      sram_rd_en   = 1'b0;
      sram_wr_en   = 1'b0;
    end
  end

  // Steer returned read byte to the lane that issued the read; others stay 0.
  always_comb begin
    eng_rd_data = {(NUM_REQ*8){1'b0}};
    for (int i = 0; i < NUM_REQ; i++) begin
      if (rd_vld_r && (rd_owner_r == ID_W'(i))) begin
        eng_rd_data[i*8 +: 8] = sram_rd_data;
      end else begin
        eng_rd_data[i*8 +: 8] = 8'h00;
      end
    end
  end

  assign grant    = grant_r;
  assign owner_id = owner_id_r;
  assign wdog_err = wdog_err_r;

endmodule
